// File: rtl/multileg_spwm.sv
// multileg_spwm: multi-leg sinusoidal PWM modulator with dead-time and fault latch.
//
// A shared up/down counter builds a symmetric triangular carrier.  Each leg
// compares its double-buffered modulator against the carrier and drives a
// complementary half-bridge pair through a four-state FSM
// (OFF / HI / LO / DEAD) that enforces a dead gap between gates.
//
// Ports
//   clk          single rising-edge clock
//   rst          synchronous, active-high reset
//   i_enable     one-cycle carrier step tick
//   i_mod        signed modulators; leg k in [k*NB_DATA +: NB_DATA]
//   i_mod_valid  loads i_mod into the shadow registers
//   i_leg_en     per-leg enables
//   i_dt         dead-time count, sampled when a dead counter loads
//   i_fault      fault input, sampled on clk
//   i_fault_clr  fault clear request
//   o_pwm        gates; bit 2k = leg k high side, bit 2k+1 = leg k low side
//   o_carrier    signed triangular carrier
//   o_sync       one-cycle pulse when the carrier reaches its valley
//   o_fault      latched fault flag
module multileg_spwm #(
   parameter int NB_DATA       = 16,
   parameter int N_LEGS        = 2,
   parameter int CARRIER_STEPS = 30,
   parameter int NB_DT         = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_enable,
   input  logic [N_LEGS*NB_DATA-1:0]   i_mod,
   input  logic                        i_mod_valid,
   input  logic [N_LEGS-1:0]           i_leg_en,
   input  logic [NB_DT-1:0]            i_dt,
   input  logic                        i_fault,
   input  logic                        i_fault_clr,
   output logic [2*N_LEGS-1:0]         o_pwm,
   output logic [NB_DATA-1:0]          o_carrier,
   output logic                        o_sync,
   output logic                        o_fault
);

   localparam int CW = $clog2(CARRIER_STEPS + 1);
   localparam logic [NB_DATA-1:0] CAR_MIN = {1'b1, {(NB_DATA-1){1'b0}}};
   localparam logic [NB_DATA-1:0] STEP =
      NB_DATA'(((64'd1 << NB_DATA) - 64'd1) / 64'(CARRIER_STEPS));

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_HI   = 2'd1,
      S_LO   = 2'd2,
      S_DEAD = 2'd3
   } leg_state_t;

   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        dir_up_q, dir_up_d;
   logic [NB_DATA-1:0]          carrier_q, carrier_d;
   logic                        sync_q, sync_d;
   logic                        fault_q, fault_d;
   logic [N_LEGS*NB_DATA-1:0]   shadow_q, shadow_d;
   logic [N_LEGS*NB_DATA-1:0]   active_q, active_d;
   logic [N_LEGS-1:0]           raw_q, raw_d;
   leg_state_t                  state_q [N_LEGS];
   leg_state_t                  state_d [N_LEGS];
   logic [N_LEGS-1:0]           tgt_q, tgt_d;
   logic [NB_DT-1:0]            dcnt_q [N_LEGS];
   logic [NB_DT-1:0]            dcnt_d [N_LEGS];
   logic [2*N_LEGS-1:0]         pwm_q, pwm_d;

   // Carrier counter, carrier value and valley pulse.
   always_comb begin
      cnt_d    = cnt_q;
      dir_up_d = dir_up_q;
      if (i_enable) begin
         if (dir_up_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(CARRIER_STEPS)) begin
               dir_up_d = 1'b0;
            end else begin
               dir_up_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_d == {CW{1'b0}}) begin
               dir_up_d = 1'b1;
            end else begin
               dir_up_d = 1'b0;
            end
         end
      end else begin
         cnt_d    = cnt_q;
         dir_up_d = dir_up_q;
      end
      // Offset-binary style: adding from the most negative value wraps correctly.
      carrier_d = CAR_MIN + (NB_DATA'(cnt_d) * STEP);
      sync_d    = i_enable && (cnt_d == {CW{1'b0}});
   end

   // Fault latch: a set request wins over a simultaneous clear.
   always_comb begin
      if (i_fault) begin
         fault_d = 1'b1;
      end else if (i_fault_clr) begin
         fault_d = 1'b0;
      end else begin
         fault_d = fault_q;
      end
   end

   // Modulator double buffer; a write on the transfer cycle goes straight to active.
   always_comb begin
      if (i_mod_valid) begin
         shadow_d = i_mod;
      end else begin
         shadow_d = shadow_q;
      end
      if (sync_q) begin
         active_d = i_mod_valid ? i_mod : shadow_q;
      end else begin
         active_d = active_q;
      end
   end

   // Strict signed comparison of each active modulator against the carrier.
   always_comb begin
      raw_d = {N_LEGS{1'b0}};
      for (int k = 0; k < N_LEGS; k++) begin
         raw_d[k] = $signed(active_q[k*NB_DATA +: NB_DATA]) > $signed(carrier_q);
      end
   end

   // Per-leg dead-time FSM next state and gate decode.
   always_comb begin
      pwm_d = {(2*N_LEGS){1'b0}};
      tgt_d = tgt_q;
      for (int k = 0; k < N_LEGS; k++) begin
         state_d[k] = state_q[k];
         dcnt_d[k]  = dcnt_q[k];
         // fault_d (not fault_q) so gates drop on the same edge the fault latches.
         if (!i_leg_en[k] || fault_d) begin
            state_d[k] = S_OFF;
            dcnt_d[k]  = {NB_DT{1'b0}};
         end else begin
            case (state_q[k])
               S_OFF: begin
                  state_d[k] = S_DEAD;
                  tgt_d[k]   = raw_q[k];
                  dcnt_d[k]  = i_dt;
               end
               S_HI: begin
                  if (!raw_q[k]) begin
                     state_d[k] = S_DEAD;
                     tgt_d[k]   = 1'b0;
                     dcnt_d[k]  = i_dt;
                  end else begin
                     state_d[k] = S_HI;
                  end
               end
               S_LO: begin
                  if (raw_q[k]) begin
                     state_d[k] = S_DEAD;
                     tgt_d[k]   = 1'b1;
                     dcnt_d[k]  = i_dt;
                  end else begin
                     state_d[k] = S_LO;
                  end
               end
               S_DEAD: begin
                  if (raw_q[k] != tgt_q[k]) begin
                     tgt_d[k]  = raw_q[k];
                     dcnt_d[k] = i_dt;
                  end else if (dcnt_q[k] == {NB_DT{1'b0}}) begin
                     state_d[k] = tgt_q[k] ? S_HI : S_LO;
                  end else begin
                     dcnt_d[k] = dcnt_q[k] - NB_DT'(1);
                  end
               end
               default: begin
                  state_d[k] = S_OFF;
                  dcnt_d[k]  = {NB_DT{1'b0}};
               end
            endcase
         end
         case (state_d[k])
            S_HI:    pwm_d[2*k +: 2] = 2'b01;
            S_LO:    pwm_d[2*k +: 2] = 2'b10;
            default: pwm_d[2*k +: 2] = 2'b00;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= {CW{1'b0}};
         dir_up_q  <= 1'b1;
         carrier_q <= CAR_MIN;
         sync_q    <= 1'b0;
         fault_q   <= 1'b0;
         shadow_q  <= {(N_LEGS*NB_DATA){1'b0}};
         active_q  <= {(N_LEGS*NB_DATA){1'b0}};
         raw_q     <= {N_LEGS{1'b0}};
         tgt_q     <= {N_LEGS{1'b0}};
         pwm_q     <= {(2*N_LEGS){1'b0}};
         for (int k = 0; k < N_LEGS; k++) begin
            state_q[k] <= S_OFF;
            dcnt_q[k]  <= {NB_DT{1'b0}};
         end
      end else begin
         cnt_q     <= cnt_d;
         dir_up_q  <= dir_up_d;
         carrier_q <= carrier_d;
         sync_q    <= sync_d;
         fault_q   <= fault_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         raw_q     <= raw_d;
         tgt_q     <= tgt_d;
         pwm_q     <= pwm_d;
         for (int k = 0; k < N_LEGS; k++) begin
            state_q[k] <= state_d[k];
            dcnt_q[k]  <= dcnt_d[k];
         end
      end
   end

   assign o_pwm     = pwm_q;
   assign o_carrier = carrier_q;
   assign o_sync    = sync_q;
   assign o_fault   = fault_q;

endmodule

// File: tb/tb_multileg_spwm.sv
// Self-checking bench for multileg_spwm (default parameters).
// A cycle-level reference model predicts the outputs after each clock edge and
// queues them; an independent monitor pops and compares one entry per cycle.
module tb_multileg_spwm;

   localparam int CS   = 30;
   localparam int STEP = 65535 / CS;   // 2184

   logic        clk = 1'b0;
   logic        rst, i_enable, i_mod_valid, i_fault, i_fault_clr;
   logic [31:0] i_mod;
   logic [1:0]  i_leg_en;
   logic [3:0]  i_dt;
   logic [3:0]  o_pwm;
   logic [15:0] o_carrier;
   logic        o_sync, o_fault;

   always #5 clk = ~clk;

   multileg_spwm dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_mod(i_mod),
      .i_mod_valid(i_mod_valid), .i_leg_en(i_leg_en), .i_dt(i_dt),
      .i_fault(i_fault), .i_fault_clr(i_fault_clr), .o_pwm(o_pwm),
      .o_carrier(o_carrier), .o_sync(o_sync), .o_fault(o_fault)
   );

   typedef struct {
      logic [3:0] pwm;
      int         car;
      logic       sync;
      logic       fault;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   done  = 1'b0;

   // Reference model: phase position in the period, gate actually driven
   // (0 none, 1 high, 2 low), pending side and remaining gap cycles.
   int m_phase, m_car;
   bit m_sync, m_fault;
   int m_shadow[2], m_active[2];
   bit m_raw[2];
   int m_gate[2], m_want[2], m_hold[2];
   bit m_pend[2];

   function automatic int leg_mod(input logic [31:0] v, input int k);
      logic [15:0] s;
      s = v[k*16 +: 16];
      return int'($signed(s));
   endfunction

   task automatic model_step();
      int  c, old_car, need;
      bit  old_sync;
      exp_t e;
      if (rst) begin
         m_phase = 0; m_car = -32768; m_sync = 1'b0; m_fault = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_shadow[k] = 0; m_active[k] = 0; m_raw[k] = 1'b0;
            m_gate[k] = 0; m_pend[k] = 1'b0; m_hold[k] = 0; m_want[k] = 0;
         end
      end else begin
         old_car  = m_car;
         old_sync = m_sync;
         if (i_enable) m_phase = (m_phase + 1) % (2*CS);
         c = (m_phase <= CS) ? m_phase : 2*CS - m_phase;
         m_car  = -32768 + c*STEP;
         m_sync = i_enable && (m_phase == 0);
         m_fault = i_fault ? 1'b1 : (i_fault_clr ? 1'b0 : m_fault);
         for (int k = 0; k < 2; k++) begin
            need = m_raw[k] ? 1 : 2;
            if (!i_leg_en[k] || m_fault) begin
               m_gate[k] = 0; m_pend[k] = 1'b0; m_hold[k] = 0;
            end else if (m_gate[k] != 0) begin
               if (need != m_gate[k]) begin
                  m_gate[k] = 0; m_pend[k] = 1'b1; m_want[k] = need; m_hold[k] = int'(i_dt);
               end
            end else if (!m_pend[k]) begin
               m_pend[k] = 1'b1; m_want[k] = need; m_hold[k] = int'(i_dt);
            end else if (need != m_want[k]) begin
               m_want[k] = need; m_hold[k] = int'(i_dt);
            end else if (m_hold[k] == 0) begin
               m_gate[k] = m_want[k]; m_pend[k] = 1'b0;
            end else begin
               m_hold[k]--;
            end
         end
         for (int k = 0; k < 2; k++) begin
            m_raw[k] = m_active[k] > old_car;
            if (old_sync) m_active[k] = i_mod_valid ? leg_mod(i_mod, k) : m_shadow[k];
            if (i_mod_valid) m_shadow[k] = leg_mod(i_mod, k);
         end
      end
      e.pwm = 4'b0000;
      for (int k = 0; k < 2; k++) begin
         if (m_gate[k] == 1) e.pwm[2*k]   = 1'b1;
         if (m_gate[k] == 2) e.pwm[2*k+1] = 1'b1;
      end
      e.car = m_car; e.sync = m_sync; e.fault = m_fault;
      exp_q.push_back(e);
   endtask

   // Inputs are set at a falling edge; predict the next rising edge, then advance.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one output set per cycle, sampled just after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pwm", o_pwm, e.pwm);
            chk("carrier", int'($signed(o_carrier)), e.car);
            chk("sync", o_sync, e.sync);
            chk("fault", o_fault, e.fault);
            chk("no_overlap_leg0", o_pwm[1:0] == 2'b11, 0);
            chk("no_overlap_leg1", o_pwm[3:2] == 2'b11, 0);
         end else if (!done) begin
            tests++; fails++;
            $display("FAIL scoreboard_empty: got none expected one entry at %0t", $time);
         end
      end
   end

   task automatic wait_sync(input int budget);
      for (int i = 0; i < budget && !m_sync; i++) tick();
      if (!m_sync) begin
         tests++; fails++;
         $display("FAIL sync_timeout: got 0 expected 1 within %0d cycles", budget);
      end
   endtask

   initial begin
      rst = 1'b1; i_enable = 1'b0; i_mod = 32'h0; i_mod_valid = 1'b0;
      i_leg_en = 2'b00; i_dt = 4'd0; i_fault = 1'b0; i_fault_clr = 1'b0;
      // Reset, then free-running carrier over two periods.
      tick(); tick();
      rst = 1'b0; i_enable = 1'b1;
      repeat (130) tick();
      // Leg 0 at zero modulation with dead time 3.
      i_mod = 32'h0; i_mod_valid = 1'b1; tick(); i_mod_valid = 1'b0;
      i_dt = 4'd3; i_leg_en = 2'b01;
      repeat (200) tick();
      // Mid-period write, then a write coincident with the valley pulse.
      for (int i = 0; i < 100 && m_phase != 15; i++) tick();
      i_mod = {16'h0000, 16'h4000}; i_mod_valid = 1'b1; tick(); i_mod_valid = 1'b0;
      repeat (130) tick();
      wait_sync(100);
      i_mod = {16'h2000, 16'hC000}; i_mod_valid = 1'b1; tick(); i_mod_valid = 1'b0;
      i_leg_en = 2'b11;
      repeat (130) tick();
      // Fault pulse, clear, and simultaneous fault+clear.
      i_fault = 1'b1; tick(); i_fault = 1'b0;
      repeat (20) tick();
      i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
      repeat (40) tick();
      i_fault = 1'b1; i_fault_clr = 1'b1; tick(); i_fault = 1'b0; i_fault_clr = 1'b0;
      repeat (10) tick();
      i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
      repeat (20) tick();
      // Full-scale modulators, then drop leg 1.
      i_mod = {16'h8000, 16'h7FFF}; i_mod_valid = 1'b1; tick(); i_mod_valid = 1'b0;
      repeat (150) tick();
      i_leg_en = 2'b01;
      repeat (10) tick();
      // Maximum dead time, reset while in the dead gap.
      i_dt = 4'd15; i_leg_en = 2'b00; tick();
      i_leg_en = 2'b11; repeat (5) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (40) tick();
      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(299) == 0);
         i_enable = ($urandom_range(2) != 0);
         i_mod_valid = ($urandom_range(19) == 0);
         if (i_mod_valid) begin
            i_mod = $urandom;
            if ($urandom_range(3) == 0) i_mod[15:0]  = ($urandom_range(1) == 0) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(3) == 0) i_mod[31:16] = ($urandom_range(1) == 0) ? 16'h7FFF : 16'h8000;
         end
         if ($urandom_range(49) == 0) i_leg_en = 2'($urandom_range(3));
         i_dt = 4'($urandom_range(15));
         i_fault = ($urandom_range(149) == 0);
         i_fault_clr = ($urandom_range(39) == 0);
         tick();
      end
      done = 1'b1;
      repeat (2) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multileg_spwm.md
MULTILEG_SPWM -- requirements
Module: multileg_spwm

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 16, meaning the modulator/carrier width in signed format S(NB_DATA,NB_DATA-1).
REQ-002 The block SHALL have parameter N_LEGS, default 2, meaning the number of half-bridge legs.
REQ-003 The block SHALL have parameter CARRIER_STEPS, default 30, meaning the carrier ticks per half-period.
REQ-004 The block SHALL have parameter NB_DT, default 4, meaning the dead-time field width.
REQ-005 The block SHALL have a clock input, clk, 1 bit, which is the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have a reset input, rst, 1 bit; reset SHALL be synchronous and active-high.
REQ-007 The block SHALL have an input, i_enable, 1 bit, which is the carrier step tick and is one clk wide.
REQ-008 The block SHALL have an input, i_mod, N_LEGS*NB_DATA bits, holding the signed modulators; leg k SHALL occupy bits [k*NB_DATA +: NB_DATA].
REQ-009 The block SHALL have an input, i_mod_valid, 1 bit, which writes i_mod into the shadow registers.
REQ-010 The block SHALL have an input, i_leg_en, N_LEGS bits, holding the per-leg enables.
REQ-011 The block SHALL have an input, i_dt, NB_DT bits, holding the dead-time count.
REQ-012 The block SHALL have an input, i_fault, 1 bit, which is the asynchronous-source fault and is sampled on clk.
REQ-013 The block SHALL have an input, i_fault_clr, 1 bit, which is the fault clear request.
REQ-014 The block SHALL have an output, o_pwm, 2*N_LEGS bits, carrying the gate outputs; bit 2k SHALL be the leg k high side and bit 2k+1 SHALL be the leg k low side.
REQ-015 The block SHALL have an output, o_carrier, NB_DATA bits, carrying the signed triangular carrier.
REQ-016 The block SHALL have an output, o_sync, 1 bit, carrying a one-cycle pulse at the carrier valley.
REQ-017 The block SHALL have an output, o_fault, 1 bit, carrying the latched fault flag.

Function
REQ-018 The carrier counter cnt SHALL advance only on cycles with i_enable=1, following the sequence 0,1,…,CARRIER_STEPS,CARRIER_STEPS-1,…,1,0,1,…, so that one period is 2*CARRIER_STEPS ticks.
REQ-019 The carrier SHALL be registered as o_carrier = -2^(NB_DATA-1) + cnt*STEP, where STEP = floor((2^NB_DATA-1)/CARRIER_STEPS) is a constant; with the default parameters, STEP SHALL be 2184 and the peak SHALL be 32752.
REQ-020 o_sync SHALL be 1 for exactly the cycle in which cnt is updated to 0.
REQ-021 When i_mod_valid=1, the shadow register SHALL be loaded with i_mod.
REQ-022 On the o_sync cycle, the shadow register SHALL be transferred to the active register.
REQ-023 If i_mod_valid=1 and a valley transfer occur in the same cycle, i_mod SHALL bypass the shadow register directly into the active register.
REQ-024 The raw comparison raw[k] SHALL be registered as (active[k] > o_carrier), using a signed, strict comparison; equality SHALL yield 0.
REQ-025 Each leg SHALL implement a state machine with states OFF, HI, LO and DEAD, whose outputs SHALL be: HI gives high side 1 and low side 0; LO gives high side 0 and low side 1; OFF and DEAD give both sides 0.
REQ-026 When in HI or LO and raw[k] demands the opposite side, the leg SHALL enter DEAD with target equal to the opposite side and SHALL load the dead counter with i_dt.
REQ-027 While in DEAD, if the dead counter is 0 the leg SHALL go to its target state; otherwise the counter SHALL decrement.
REQ-028 The gap between one side falling and the other rising SHALL be exactly i_dt+1 cycles; when i_dt=0 the gap SHALL be 1 cycle.
REQ-029 If raw[k] changes while a leg is in DEAD, the target SHALL be updated and the counter SHALL be reloaded with i_dt.
REQ-030 i_dt SHALL be sampled only when the dead counter is loaded.
REQ-031 If i_leg_en[k]=0 or o_fault=1, leg k SHALL go to OFF on the next cycle.
REQ-032 From OFF, when the leg is enabled and no fault is present, the leg SHALL enter DEAD with target taken from raw[k], so that no gate rises without a full dead-time gap.
REQ-033 Both outputs of a leg SHALL never be 1 in the same cycle, under any input sequence.
REQ-034 o_fault SHALL be set on the cycle after i_fault=1 is sampled, and o_pwm SHALL be all 0 in that same cycle.
REQ-035 o_fault SHALL hold until i_fault_clr=1 while i_fault=0; if i_fault and i_fault_clr are both 1 in the same cycle, o_fault SHALL stay 1.
REQ-036 The carrier SHALL keep running during a fault.
REQ-037 A modulator value of 2^(NB_DATA-1)-1 SHALL drive the high side permanently after the initial dead gap, and a value of -2^(NB_DATA-1) SHALL drive the low side permanently.

Reset
REQ-038 When rst=1, the block SHALL force: o_pwm=0, all legs to OFF, cnt=0 with direction up, o_carrier=-2^(NB_DATA-1), o_sync=0, o_fault=0, shadow and active registers=0, raw=0, and dead counters=0.
REQ-039 Reset asserted mid-operation SHALL take effect at the next edge, and i_enable SHALL be ignored while rst=1.

Verification
REQ-040 The bench SHALL cover this case: rst=1 for 2 cycles, then i_enable=1 every cycle -> o_carrier shall read -32768, -30584, …, 32752 at tick 30, then 30568, …; o_sync shall pulse at tick 60.
REQ-041 The bench SHALL cover this case: leg0 mod=0, i_dt=3, leg enabled -> at each carrier crossing the active side shall fall, both sides shall be 0 for 4 cycles, and then the other side shall rise; no overlap shall occur.
REQ-042 The bench SHALL cover this case: i_mod_valid pulse with leg0=16384 mid-period -> the raw threshold shall change only on the next o_sync cycle; a write coincident with o_sync shall take effect in that period.
REQ-043 The bench SHALL cover this case: a 1-cycle i_fault pulse while switching -> o_pwm=0 and o_fault=1 on the next cycle, holding thereafter; i_fault_clr with i_fault=0 -> o_fault=0, and legs shall restart via DEAD with an (i_dt+1)-cycle gap; i_fault and i_fault_clr both 1 in the same cycle -> o_fault shall remain 1.
REQ-044 The bench SHALL cover this case: leg0 mod=32767 and leg1 mod=-32768 -> leg0 high side shall be constantly 1 and leg1 low side shall be constantly 1 after the initial gap; dropping i_leg_en[1] -> leg1 outputs shall be 00 on the next cycle.
REQ-045 The bench SHALL cover this case: rst asserted during DEAD with i_dt=15 -> o_pwm=0 on the next edge and cnt=0; after release, the first gate shall rise no earlier than i_dt+1 cycles after the leg is enabled.
